// File: rtl/ledwalk_checker_pkg.sv
// ============================================================================
// Module : ledwalk_checker_pkg
// Brief  : Shared FSM state and direction encodings for the LED walk checker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ledwalk_checker_pkg;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_SEEN = 2'd1,
    ST_UP   = 2'd2,
    ST_DOWN = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ledwalk_checker_onehot_decode.sv
// ============================================================================
// Module : led_onehot_decode
// Brief  : Combinational one-hot check and bit-position decode of the LED bus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module led_onehot_decode #(
  parameter int NLEDS = 8
) (
  input  logic [NLEDS-1:0]         led,
  output logic                     valid,
  output logic [$clog2(NLEDS)-1:0] index
);

  localparam int IW = $clog2(NLEDS);

  assign valid = ($countones(led) == 1);

  // Index is only meaningful when valid; with several bits set the highest wins.
  always_comb begin
    index = '0;
    for (int i = 0; i < NLEDS; i++) begin
      if (led[i]) index = IW'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ledwalk_checker.sv
// ============================================================================
// Module : ledwalk_checker
// Brief  : Locks onto a back-and-forth one-hot LED sweep and flags violations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ledwalk_checker
  import ledwalk_checker_pkg::*;
#(
  parameter int NLEDS = 8,
  parameter int CNTW  = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_ce,
  input  logic [NLEDS-1:0]         i_led,
  output logic                     o_locked,
  output logic [$clog2(NLEDS)-1:0] o_index,
  output logic                     o_dir,
  output logic                     o_err,
  output logic [CNTW-1:0]          o_err_count,
  output logic [CNTW-1:0]          o_bounce_count
);

  localparam int            IW     = $clog2(NLEDS);
  localparam logic [IW-1:0] IDX_TOP = IW'(NLEDS - 1);
  localparam logic [IW-1:0] IDX_BOT = '0;
  localparam logic [IW-1:0] ONE     = IW'(1);

  state_t           state, state_nx;
  logic [NLEDS-1:0] prev_led;
  logic [IW-1:0]    index_q, index_nx;
  logic             dir_q, dir_nx;
  logic             err_q, err_nx;
  logic             bounce;
  logic [CNTW-1:0]  err_cnt, bnc_cnt;

  logic             s_valid;
  logic [IW-1:0]    s_index;
  logic             changed, step_up, step_dn;

  led_onehot_decode #(.NLEDS(NLEDS)) u_decode (
    .led   (i_led),
    .valid (s_valid),
    .index (s_index)
  );

  assign changed = (i_led != prev_led);
  // Endpoint guards keep the +1/-1 compares from ever relying on wrap-around.
  assign step_up = (index_q != IDX_TOP) && (s_index == index_q + ONE);
  assign step_dn = (index_q != IDX_BOT) && (s_index == index_q - ONE);

  always_comb begin
    state_nx = state;
    index_nx = index_q;
    dir_nx   = dir_q;
    err_nx   = 1'b0;
    bounce   = 1'b0;
    if (i_ce) begin
      case (state)
        ST_HUNT: begin
          if (s_valid) begin
            index_nx = s_index;
            state_nx = ST_SEEN;
          end
        end
        ST_SEEN: begin
          if (s_valid && !changed) begin
            state_nx = ST_SEEN;
          end else if (s_valid && step_up) begin
            index_nx = s_index;
            dir_nx   = DIR_UP;
            state_nx = ST_UP;
          end else if (s_valid && step_dn) begin
            index_nx = s_index;
            dir_nx   = DIR_DOWN;
            state_nx = ST_DOWN;
          end else begin
            state_nx = ST_HUNT;
          end
        end
        ST_UP: begin
          if (s_valid && !changed) begin
            state_nx = ST_UP;
          end else if (s_valid && index_q == IDX_TOP && s_index == IDX_TOP - ONE) begin
            index_nx = s_index;
            dir_nx   = DIR_DOWN;
            bounce   = 1'b1;
            state_nx = ST_DOWN;
          end else if (s_valid && step_up) begin
            index_nx = s_index;
          end else begin
            err_nx   = 1'b1;
            state_nx = ST_HUNT;
          end
        end
        ST_DOWN: begin
          if (s_valid && !changed) begin
            state_nx = ST_DOWN;
          end else if (s_valid && index_q == IDX_BOT && s_index == IDX_BOT + ONE) begin
            index_nx = s_index;
            dir_nx   = DIR_UP;
            bounce   = 1'b1;
            state_nx = ST_UP;
          end else if (s_valid && step_dn) begin
            index_nx = s_index;
          end else begin
            err_nx   = 1'b1;
            state_nx = ST_HUNT;
          end
        end
        default: state_nx = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_HUNT;
      prev_led <= '0;
      index_q  <= '0;
      dir_q    <= DIR_UP;
      err_q    <= 1'b0;
      err_cnt  <= '0;
      bnc_cnt  <= '0;
    end else begin
      state   <= state_nx;
      index_q <= index_nx;
      dir_q   <= dir_nx;
      err_q   <= err_nx;
      if (i_ce) prev_led <= i_led;
      if (err_nx && err_cnt != {CNTW{1'b1}}) err_cnt <= err_cnt + 1'b1;
      if (bounce && bnc_cnt != {CNTW{1'b1}}) bnc_cnt <= bnc_cnt + 1'b1;
    end
  end

  assign o_locked       = (state == ST_UP) || (state == ST_DOWN);
  assign o_index        = index_q;
  assign o_dir          = dir_q;
  assign o_err          = err_q;
  assign o_err_count    = err_cnt;
  assign o_bounce_count = bnc_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ledwalk_checker.sv
// ============================================================================
// Module : tb_ledwalk_checker
// Brief  : Self-checking bench: vector table, corner sequences, random vs model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ledwalk_checker;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [7:0] led;

  logic       locked, dir, err;
  logic [2:0] index;
  logic [7:0] err_count, bounce_count;
  logic       s_locked, s_dir, s_err;
  logic [2:0] s_index;
  logic [1:0] s_err_count, s_bounce_count;

  always #5 clk = ~clk;

  ledwalk_checker #(.NLEDS(8), .CNTW(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_led(led),
    .o_locked(locked), .o_index(index), .o_dir(dir), .o_err(err),
    .o_err_count(err_count), .o_bounce_count(bounce_count)
  );

  ledwalk_checker #(.NLEDS(8), .CNTW(2)) dut_small (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_led(led),
    .o_locked(s_locked), .o_index(s_index), .o_dir(s_dir), .o_err(s_err),
    .o_err_count(s_err_count), .o_bounce_count(s_bounce_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: anchor/lock flags, position, signed step of +1/-1.
  int m_anchor, m_locked, m_pos, m_step, m_ec, m_bc, m_err;
  logic [7:0] m_prev;

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_anchor = 0; m_locked = 0; m_pos = 0; m_step = 1;
    m_ec = 0; m_bc = 0; m_err = 0; m_prev = 8'h00;
  endtask

  task automatic model_sample(input logic [7:0] s);
    int valid, p, es;
    valid = ($countones(s) == 1);
    p = 0;
    for (int i = 0; i < N; i++) if (s[i]) p = i;
    m_err = 0;
    if (m_locked != 0) begin
      if (!(valid != 0 && s == m_prev)) begin
        es = (m_pos + m_step >= 0 && m_pos + m_step <= N - 1) ? m_step : -m_step;
        if (valid != 0 && p == m_pos + es) begin
          if (es != m_step) m_bc++;
          m_step = es;
          m_pos  = p;
        end else begin
          m_err = 1; m_ec++; m_locked = 0; m_anchor = 0;
        end
      end
    end else if (m_anchor != 0) begin
      if (!(valid != 0 && s == m_prev)) begin
        if (valid != 0 && (p - m_pos == 1 || m_pos - p == 1)) begin
          m_step = p - m_pos; m_pos = p; m_locked = 1;
        end else begin
          m_anchor = 0;
        end
      end
    end else if (valid != 0) begin
      m_anchor = 1; m_pos = p;
    end
    m_prev = s;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input int lk, input int idx, input int dr, input int er,
                         input int ec, input int bc);
    chk("locked", int'(locked), lk);
    chk("index", int'(index), idx);
    chk("dir", int'(dir), dr);
    chk("err", int'(err), er);
    chk("err_count", int'(err_count), sat(ec, 255));
    chk("bounce_count", int'(bounce_count), sat(bc, 255));
    chk("small_err_count", int'(s_err_count), sat(ec, 3));
    chk("small_bounce_count", int'(s_bounce_count), sat(bc, 3));
  endtask

  // One clock: drive, let the edge happen, update model, sample 1ns later.
  task automatic cyc(input logic r, input logic e, input logic [7:0] l);
    rst = r; ce = e; led = l;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else if (e) model_sample(l);
    else m_err = 0;
  endtask

  task automatic cyc_model(input logic r, input logic e, input logic [7:0] l);
    cyc(r, e, l);
    chk_all(m_locked, m_pos, (m_step < 0) ? 1 : 0, m_err, m_ec, m_bc);
  endtask

  typedef struct {
    logic       ce;
    logic [7:0] led;
    int         lk, idx, dr, er, ec, bc;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic c, input logic [7:0] l, input int lk, input int idx,
                     input int dr, input int er, input int ec, input int bc);
    vec_t v;
    v.ce = c; v.led = l; v.lk = lk; v.idx = idx; v.dr = dr; v.er = er; v.ec = ec; v.bc = bc;
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] nl;
    int r, np;

    // Full sweep, error recovery, invalid patterns, holds and ce gating.
    add(1, 8'h01, 0, 0, 0, 0, 0, 0);
    add(1, 8'h02, 1, 1, 0, 0, 0, 0);
    add(1, 8'h04, 1, 2, 0, 0, 0, 0);
    add(1, 8'h08, 1, 3, 0, 0, 0, 0);
    add(1, 8'h10, 1, 4, 0, 0, 0, 0);
    add(1, 8'h20, 1, 5, 0, 0, 0, 0);
    add(1, 8'h40, 1, 6, 0, 0, 0, 0);
    add(1, 8'h80, 1, 7, 0, 0, 0, 0);
    add(1, 8'h40, 1, 6, 1, 0, 0, 1);
    add(1, 8'h20, 1, 5, 1, 0, 0, 1);
    add(1, 8'h10, 1, 4, 1, 0, 0, 1);
    add(1, 8'h08, 1, 3, 1, 0, 0, 1);
    add(1, 8'h04, 1, 2, 1, 0, 0, 1);
    add(1, 8'h02, 1, 1, 1, 0, 0, 1);
    add(1, 8'h01, 1, 0, 1, 0, 0, 1);
    add(1, 8'h02, 1, 1, 0, 0, 0, 2);
    add(1, 8'h04, 1, 2, 0, 0, 0, 2);
    add(1, 8'h08, 1, 3, 0, 0, 0, 2);
    add(1, 8'h20, 0, 3, 0, 1, 1, 2);
    add(1, 8'h40, 0, 6, 0, 0, 1, 2);
    add(1, 8'h80, 1, 7, 0, 0, 1, 2);
    add(1, 8'h40, 1, 6, 1, 0, 1, 3);
    add(1, 8'h18, 0, 6, 1, 1, 2, 3);
    add(1, 8'h00, 0, 6, 1, 0, 2, 3);
    add(0, 8'hFF, 0, 6, 1, 0, 2, 3);
    add(1, 8'h10, 0, 4, 1, 0, 2, 3);
    add(1, 8'h10, 0, 4, 1, 0, 2, 3);
    add(1, 8'h20, 1, 5, 0, 0, 2, 3);
    add(0, 8'h81, 1, 5, 0, 0, 2, 3);
    add(1, 8'h20, 1, 5, 0, 0, 2, 3);
    add(1, 8'h40, 1, 6, 0, 0, 2, 3);

    model_reset();
    cyc(1, 0, 8'h00);
    cyc(1, 0, 8'h00);
    chk_all(0, 0, 0, 0, 0, 0);

    foreach (tbl[k]) begin
      cyc(0, tbl[k].ce, tbl[k].led);
      chk_all(tbl[k].lk, tbl[k].idx, tbl[k].dr, tbl[k].er, tbl[k].ec, tbl[k].bc);
    end

    // Five injected errors: small instance must stick at 3.
    cyc_model(1, 0, 8'h00);
    for (int e = 0; e < 5; e++) begin
      cyc_model(0, 1, 8'h01);
      cyc_model(0, 1, 8'h02);
      cyc_model(0, 1, 8'h08);
    end
    chk("small_err_sat", int'(s_err_count), 3);

    // Sample enable every 4th cycle with the LED held for 4 cycles per step.
    cyc_model(1, 0, 8'h00);
    for (int s = 0; s < 20; s++) begin
      np = (s < 8) ? s : 14 - s;
      if (np < 0) np = -np;
      nl = 8'h01 << np;
      for (int c = 0; c < 4; c++) cyc_model(0, (c == 0), nl);
    end

    // Reset mid-sweep at index 5, then relock.
    cyc_model(1, 0, 8'h00);
    for (int s = 0; s < 6; s++) cyc_model(0, 1, 8'h01 << s);
    cyc(1, 1, 8'h20);
    chk_all(0, 0, 0, 0, 0, 0);
    cyc_model(0, 1, 8'h40);
    cyc_model(0, 1, 8'h80);
    chk("relock", int'(locked), 1);

    // Random: mostly legal moves, with holds, stray one-hots and garbage.
    for (int t = 0; t < 3000; t++) begin
      r = $urandom_range(0, 99);
      if (m_locked != 0) begin
        np = m_pos + m_step;
        if (np < 0 || np > N - 1) np = m_pos - m_step;
      end else if (m_anchor != 0) begin
        np = (m_pos == 0) ? 1 : (m_pos == N - 1) ? N - 2 : m_pos + (($urandom_range(0, 1) == 0) ? 1 : -1);
      end else begin
        np = $urandom_range(0, N - 1);
      end
      if (r < 70)      nl = 8'h01 << np;
      else if (r < 80) nl = m_prev;
      else if (r < 90) nl = 8'h01 << $urandom_range(0, N - 1);
      else             nl = 8'($urandom);
      cyc_model(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), nl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
